uart_echo_buffer: RTL and testbench
===================================

UART_ECHO_BUFFER -- requirements
Module: uart_echo_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning received/transmitted character width (5..8).
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, meaning the FIFO holds 2**DEPTH_LOG2 characters.
REQ-003 SHALL have parameter LCD_COLS, default 16, meaning characters per LCD line.
REQ-004 SHALL have parameter LCD_GAP, default 2500, meaning minimum CLK cycles between successive LCD writes.
REQ-005 SHALL have port CLK  input  1  system clock; all logic is on its rising edge.
REQ-006 SHALL have port RST  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port RX_DATA  input  DATA_W  character from the serial receiver, stable while RX_RDY is high.
REQ-008 SHALL have port RX_RDY  input  1  receiver character-ready level (foreign domain).
REQ-009 SHALL have port RX_ACK  output  1  read-acknowledge level to the receiver.
REQ-010 SHALL have port TX_DATA  output  DATA_W  character to the serial transmitter.
REQ-011 SHALL have port TX_SEND  output  1  transmit request level.
REQ-012 SHALL have port TX_DONE  input  1  transmitter idle level (low while sending, foreign domain).
REQ-013 SHALL have port LCD_DATA  output  9  {RS, byte} to the LCD character writer.
REQ-014 SHALL have port LCD_WR  output  1  single-cycle write strobe to the LCD writer.
REQ-015 SHALL have port LED  output  8  last character accepted into the FIFO, zero-extended.
REQ-016 SHALL have port COUNT  output  DEPTH_LOG2+1  current FIFO occupancy.
REQ-017 SHALL have port OVERFLOW  output  1  sticky flag: a character was dropped because the FIFO was full.

Function
REQ-018 SHALL pass RX_RDY and TX_DONE through two-flop synchronisers; all decisions use the synchronised values.
REQ-019 SHALL run a capture FSM: C_IDLE -> (RX_RDY_s high) -> C_PUSH -> (one cycle) -> C_ACK, with RX_ACK high in C_ACK, then -> C_IDLE when RX_RDY_s is low, dropping RX_ACK.
REQ-020 SHALL, in C_PUSH, write RX_DATA into the FIFO and update LED when not full; when full, drop the character, set OVERFLOW, and still complete the RX_ACK handshake.
REQ-021 SHALL, when a push and a pop occur in the same cycle, apply both, with COUNT unchanged; pointers wrap modulo 2**DEPTH_LOG2.
REQ-022 SHALL run a drain FSM: P_INIT, P_IDLE, P_LCD, P_GAP, P_TX, P_TXWAIT.
REQ-023 SHALL, in P_INIT after reset, issue LCD_DATA=9'h001 with one LCD_WR pulse, hold LCD_GAP cycles, then go to P_IDLE.
REQ-024 SHALL, in P_IDLE with COUNT>0, pop one character, and in P_LCD issue LCD_DATA={1'b1,char} with one LCD_WR pulse, then move to P_GAP.
REQ-025 SHALL track an LCD column counter: before character number LCD_COLS, write 9'h0C0; before character number 2*LCD_COLS, write 9'h001 and restart at column 0; each control write is followed by its own LCD_GAP wait.
REQ-026 SHALL, after P_GAP, in P_TX drive TX_DATA=char and TX_SEND=1 until TX_DONE_s is low, then enter P_TXWAIT with TX_SEND=0, and return to P_IDLE when TX_DONE_s is high.
REQ-027 SHALL never assert LCD_WR within LCD_GAP cycles of a previous LCD_WR.
REQ-028 SHALL let the capture FSM run independently of the drain FSM so that characters arriving during LCD/TX activity are buffered.

Reset
REQ-029 SHALL, while RST is low, force RX_ACK=0, TX_SEND=0, LCD_WR=0, LCD_DATA=0, TX_DATA=0, LED=0, COUNT=0, OVERFLOW=0, empty FIFO pointers, column=0, C_IDLE and P_INIT.
REQ-030 SHALL, on reset mid-operation, discard buffered characters and abort any TX request; the LCD clear of P_INIT is reissued after release.

Configuration
REQ-031 SHALL, with macro UART_ECHO_TX_EN defined, include the echo path of REQ-026.
REQ-032 SHALL, without UART_ECHO_TX_EN, hold TX_SEND=0 and TX_DATA=0, and go from P_GAP directly to P_IDLE.

Verification
REQ-033 SHALL cover reset release -> LCD_DATA=9'h001 with one LCD_WR, no further LCD_WR for 2500 cycles.
REQ-034 SHALL cover RX 8'h41 -> RX_ACK handshake, LED=8'h41, LCD_DATA=9'h141, then TX_SEND with TX_DATA=8'h41 held until TX_DONE falls.
REQ-035 SHALL cover 17 characters with TX_DONE held low (DEPTH_LOG2=4): 16 buffered, COUNT=16, 17th dropped, OVERFLOW=1, all 17 acknowledged.
REQ-036 SHALL cover 33 characters at LCD_COLS=16: 9'h0C0 before the 17th character and 9'h001 before the 33rd.
REQ-037 SHALL cover reset asserted during P_TX with 3 queued -> TX_SEND=0 and COUNT=0 immediately, P_INIT clear after release.
REQ-038 SHALL cover a build without UART_ECHO_TX_EN, 3 characters -> 3 LCD writes, TX_SEND never high.

Source files
------------

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: captures characters from a serial receiver handshake into
// a FIFO and drains them to an LCD character writer, which has a minimum
// spacing between writes. Optionally it also echoes them to the transmitter.
// Build macro UART_ECHO_TX_EN: when defined, the transmitter echo path is
// included; otherwise TX_SEND/TX_DATA stay low.
module uart_echo_buffer #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4,
   parameter int LCD_COLS   = 16,
   parameter int LCD_GAP    = 2500
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [DATA_W-1:0]   RX_DATA,
   input  logic                RX_RDY,
   output logic                RX_ACK,
   output logic [DATA_W-1:0]   TX_DATA,
   output logic                TX_SEND,
   input  logic                TX_DONE,
   output logic [8:0]          LCD_DATA,
   output logic                LCD_WR,
   output logic [7:0]          LED,
   output logic [DEPTH_LOG2:0] COUNT,
   output logic                OVERFLOW
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int COL_W = $clog2(2*LCD_COLS+1);
   localparam int GAP_W = $clog2(LCD_GAP+1);

   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
   localparam logic [COL_W-1:0]      COL_L2   = COL_W'(LCD_COLS);
   localparam logic [COL_W-1:0]      COL_CLR  = COL_W'(2*LCD_COLS);
   localparam logic [COL_W-1:0]      COL_ONE  = COL_W'(1);
   localparam logic [GAP_W-1:0]      GAP_LOAD = GAP_W'(LCD_GAP-1);
   localparam logic [GAP_W-1:0]      GAP_ONE  = GAP_W'(1);

`ifdef UART_ECHO_TX_EN
   localparam bit TX_EN = 1'b1;
`else
   localparam bit TX_EN = 1'b0;
`endif

   typedef enum logic [1:0] {C_IDLE, C_PUSH, C_ACK} cap_t;
   typedef enum logic [2:0] {P_INIT, P_IDLE, P_LCD, P_GAP, P_TX, P_TXWAIT} drn_t;

   // synchronisers
   logic rx_rdy_p0, rx_rdy_s;
   logic tx_done_p0, tx_done_s;

   // capture side
   cap_t c_state, c_next;
   logic push_req, push, full;
   logic [7:0] led_nx;

   // FIFO
   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;

   // drain side
   drn_t              p_state, p_next;
   logic              pop;
   logic [DATA_W-1:0] char_q;
   logic [7:0]        char8;
   logic              char_pend, ctl_sent, init_done;
   logic [COL_W-1:0]  col;
   logic [GAP_W-1:0]  gap_cnt;
   logic              gap_done, need_ctl;
   logic              lcd_wr_c;
   logic [8:0]        lcd_data_c;

   // Two-flop synchronisers for the foreign-domain handshake levels
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_rdy_p0  <= 1'b0;
         rx_rdy_s   <= 1'b0;
         tx_done_p0 <= 1'b1;
         tx_done_s  <= 1'b1;
      end else begin
         rx_rdy_p0  <= RX_RDY;
         rx_rdy_s   <= rx_rdy_p0;
         tx_done_p0 <= TX_DONE;
         tx_done_s  <= tx_done_p0;
      end
   end

   // Capture FSM state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) c_state <= C_IDLE;
      else      c_state <= c_next;
   end

   // Capture FSM next state: one push per receiver handshake
   always_comb begin
      c_next = c_state;
      case (c_state)
         C_IDLE:  if (rx_rdy_s) c_next = C_PUSH;
         C_PUSH:  c_next = C_ACK;
         C_ACK:   if (!rx_rdy_s) c_next = C_IDLE;
         default: c_next = C_IDLE;
      endcase
   end

   // Capture FSM outputs; a full FIFO still gets the acknowledge
   always_comb begin
      RX_ACK   = (c_state == C_ACK);
      push_req = (c_state == C_PUSH);
      full     = (COUNT == FULL_CNT);
      push     = push_req && !full;
      led_nx   = '0;
      led_nx[DATA_W-1:0] = RX_DATA;
   end

   // FIFO storage holds data only and needs no reset
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= RX_DATA;
   end

   // FIFO pointers, occupancy, last-character LED and sticky overflow
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         COUNT    <= '0;
         LED      <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            LED    <= led_nx;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   COUNT <= COUNT + CNT_ONE;
            2'b01:   COUNT <= COUNT - CNT_ONE;
            default: COUNT <= COUNT;
         endcase
         if (push_req && full) OVERFLOW <= 1'b1;
      end
   end

   // Drain FSM state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) p_state <= P_INIT;
      else      p_state <= p_next;
   end

   // Drain FSM next state; a pending character loops P_LCD/P_GAP behind control writes
   always_comb begin
      p_next = p_state;
      case (p_state)
         P_INIT:   if (init_done && gap_done) p_next = P_IDLE;
         P_IDLE:   if (COUNT != '0) p_next = P_LCD;
         P_LCD:    p_next = P_GAP;
         P_GAP:    if (gap_done) begin
                      if (char_pend)  p_next = P_LCD;
                      else if (TX_EN) p_next = P_TX;
                      else            p_next = P_IDLE;
                   end
         P_TX:     if (!tx_done_s) p_next = P_TXWAIT;
         P_TXWAIT: if (tx_done_s) p_next = P_IDLE;
         default:  p_next = P_INIT;
      endcase
   end

   // Drain FSM outputs: LCD write requests and FIFO pop
   always_comb begin
      gap_done   = (gap_cnt == '0);
      need_ctl   = ((col == COL_L2) && !ctl_sent) || (col == COL_CLR);
      char8      = '0;
      char8[DATA_W-1:0] = char_q;
      lcd_wr_c   = 1'b0;
      lcd_data_c = '0;
      pop        = 1'b0;
      case (p_state)
         P_INIT: if (!init_done) begin
                    lcd_wr_c   = 1'b1;
                    lcd_data_c = 9'h001;
                 end
         P_IDLE: pop = (COUNT != '0);
         P_LCD:  begin
                    lcd_wr_c = 1'b1;
                    if (col == COL_CLR) lcd_data_c = 9'h001;
                    else if (need_ctl)  lcd_data_c = 9'h0C0;
                    else                lcd_data_c = {1'b1, char8};
                 end
         default: ;
      endcase
   end

   // Popped character register: data only
   always_ff @(posedge CLK) begin
      if (pop) char_q <= mem[rd_ptr];
   end

   // LCD strobe, write spacing counter and column tracking
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         LCD_WR    <= 1'b0;
         LCD_DATA  <= '0;
         gap_cnt   <= '0;
         init_done <= 1'b0;
         char_pend <= 1'b0;
         ctl_sent  <= 1'b0;
         col       <= '0;
      end else begin
         LCD_WR <= lcd_wr_c;
         if (lcd_wr_c) begin
            LCD_DATA <= lcd_data_c;
            gap_cnt  <= GAP_LOAD;
         end else if (!gap_done) begin
            gap_cnt  <= gap_cnt - GAP_ONE;
         end
         if (p_state == P_INIT && lcd_wr_c) init_done <= 1'b1;
         if (pop) char_pend <= 1'b1;
         if (p_state == P_LCD) begin
            if (col == COL_CLR) begin
               col <= '0;
            end else if (need_ctl) begin
               ctl_sent <= 1'b1;
            end else begin
               col       <= col + COL_ONE;
               ctl_sent  <= 1'b0;
               char_pend <= 1'b0;
            end
         end
      end
   end

`ifdef UART_ECHO_TX_EN
   // Echo request and character held for the whole P_TX state
   always_comb begin
      TX_SEND = (p_state == P_TX);
      TX_DATA = (p_state == P_TX) ? char_q : '0;
   end
`else
   // Echo path absent: transmitter outputs tied low
   always_comb begin
      TX_SEND = 1'b0;
      TX_DATA = '0;
   end
`endif

endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb_uart_echo_buffer: randomized receiver traffic against a queue-based model
// of the expected LCD write stream (and echo stream when UART_ECHO_TX_EN is set).
`timescale 1ns/1ps
module tb_uart_echo_buffer;

   localparam int DATA_W     = 8;
   localparam int DEPTH_LOG2 = 4;
   localparam int LCD_COLS   = 16;
   localparam int LCD_GAP    = 300;
   localparam int DEPTH      = 2**DEPTH_LOG2;

   logic                CLK = 1'b0;
   logic                RST = 1'b0;
   logic [DATA_W-1:0]   RX_DATA = '0;
   logic                RX_RDY = 1'b0;
   logic                RX_ACK;
   logic [DATA_W-1:0]   TX_DATA;
   logic                TX_SEND;
   logic                TX_DONE = 1'b1;
   logic [8:0]          LCD_DATA;
   logic                LCD_WR;
   logic [7:0]          LED;
   logic [DEPTH_LOG2:0] COUNT;
   logic                OVERFLOW;

   uart_echo_buffer #(
      .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .LCD_COLS(LCD_COLS), .LCD_GAP(LCD_GAP)
   ) dut (
      .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_RDY(RX_RDY), .RX_ACK(RX_ACK),
      .TX_DATA(TX_DATA), .TX_SEND(TX_SEND), .TX_DONE(TX_DONE),
      .LCD_DATA(LCD_DATA), .LCD_WR(LCD_WR), .LED(LED), .COUNT(COUNT), .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   int         n_cmp = 0;
   int         n_fail = 0;
   logic [8:0] exp_lcd[$];
   logic [7:0] exp_tx[$];
   int         col_n = 0;
   logic [7:0] led_exp = '0;
   bit         tx_seen = 1'b0;
   int         cyc = 0;
   int         last_wr = -1000000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: reset discards everything and the display is cleared once.
   function automatic void model_reset();
      exp_lcd.delete();
      exp_tx.delete();
      col_n   = 0;
      led_exp = '0;
      exp_lcd.push_back(9'h001);
   endfunction

   // Reference model: an accepted character appears on the LCD (with line
   // changes every LCD_COLS characters) and, when enabled, on the echo.
   function automatic void model_char(input logic [7:0] c);
      if (col_n == LCD_COLS) exp_lcd.push_back(9'h0C0);
      if (col_n == 2*LCD_COLS) begin
         exp_lcd.push_back(9'h001);
         col_n = 0;
      end
      exp_lcd.push_back({1'b1, c});
      col_n++;
`ifdef UART_ECHO_TX_EN
      exp_tx.push_back(c);
`endif
   endfunction

   // LCD monitor: compares each write against the model and checks spacing.
   initial begin
      forever begin
         @(negedge CLK);
         cyc++;
         if (TX_SEND) tx_seen = 1'b1;
         if (!RST) begin
            last_wr = -1000000;
         end else if (LCD_WR) begin
            check("lcd_gap", 32'(cyc - last_wr >= LCD_GAP), 32'd1);
            last_wr = cyc;
            if (exp_lcd.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL lcd_unexpected: got write %0h, expected no write", LCD_DATA);
            end else begin
               check("lcd_data", 32'(LCD_DATA), 32'(exp_lcd.pop_front()));
            end
         end
      end
   end

`ifdef UART_ECHO_TX_EN
   // Transmitter stand-in: checks echoed characters and answers with TX_DONE.
   initial begin
      logic [7:0] txe;
      bit         have;
      int         k;
      forever begin
         @(negedge CLK);
         if (RST && TX_SEND) begin
            have = 1'b0;
            txe  = '0;
            if (exp_tx.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL tx_unexpected: got %0h, expected no echo", TX_DATA);
            end else begin
               txe  = exp_tx.pop_front();
               have = 1'b1;
               check("tx_data", 32'(TX_DATA), 32'(txe));
            end
            repeat (3) @(negedge CLK);
            if (RST && have) begin
               check("tx_send_held", 32'(TX_SEND), 32'd1);
               check("tx_data_held", 32'(TX_DATA), 32'(txe));
            end
            TX_DONE = 1'b0;
            k = 0;
            while (TX_SEND && k < 20) begin
               @(negedge CLK);
               k++;
            end
            check("tx_send_drop", 32'(TX_SEND), 32'd0);
            repeat (4) @(negedge CLK);
            TX_DONE = 1'b1;
         end
      end
   end
`endif

   // One receiver handshake; the model is updated before the stimulus starts.
   task automatic xfer(input logic [7:0] c, input bit accept);
      int k;
      if (accept) begin
         model_char(c);
         led_exp = c;
      end
      RX_DATA = c;
      RX_RDY  = 1'b1;
      k = 0;
      while (!RX_ACK && k < 30) begin
         @(negedge CLK);
         k++;
      end
      check("rx_ack_rise", 32'(RX_ACK), 32'd1);
      RX_RDY = 1'b0;
      k = 0;
      while (RX_ACK && k < 30) begin
         @(negedge CLK);
         k++;
      end
      check("rx_ack_fall", 32'(RX_ACK), 32'd0);
      check("led", 32'(LED), 32'(led_exp));
   endtask

   // Waits (bounded) until every expected write was seen, then lets the drain settle.
   task automatic wait_drain();
      int k = 0;
      int bound;
      bound = (exp_lcd.size() + exp_tx.size() + 2) * (LCD_GAP + 60);
      while ((exp_lcd.size() != 0 || exp_tx.size() != 0) && k < bound) begin
         @(negedge CLK);
         k++;
      end
      if (exp_lcd.size() != 0 || exp_tx.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d outputs pending, expected 0",
                  exp_lcd.size() + exp_tx.size());
         exp_lcd.delete();
         exp_tx.delete();
      end
      repeat (LCD_GAP + 40) @(negedge CLK);
   endtask

   task automatic check_reset_state();
      check("rst_rx_ack",   32'(RX_ACK),   32'd0);
      check("rst_tx_send",  32'(TX_SEND),  32'd0);
      check("rst_tx_data",  32'(TX_DATA),  32'd0);
      check("rst_lcd_wr",   32'(LCD_WR),   32'd0);
      check("rst_lcd_data", 32'(LCD_DATA), 32'd0);
      check("rst_led",      32'(LED),      32'd0);
      check("rst_count",    32'(COUNT),    32'd0);
      check("rst_overflow", 32'(OVERFLOW), 32'd0);
   endtask

   initial begin
      int k;
      int sent;
      int n;
      // reset from power-up
      repeat (3) @(negedge CLK);
      check_reset_state();
      model_reset();
      RST = 1'b1;
      wait_drain();

      // single known character
      xfer(8'h41, 1'b1);
      wait_drain();

      // burst into a stalled drain: first popped, 16 buffered, last dropped
      check("ovf_before", 32'(OVERFLOW), 32'd0);
      for (int i = 0; i < DEPTH + 2; i++) xfer(8'($urandom), i < DEPTH + 1);
      check("count_full", 32'(COUNT), 32'(DEPTH));
      check("overflow_set", 32'(OVERFLOW), 32'd1);
      wait_drain();
      check("overflow_sticky", 32'(OVERFLOW), 32'd1);

      // reset in the middle of draining with three characters queued
      for (int i = 0; i < 4; i++) xfer(8'($urandom), 1'b1);
      repeat (20) @(negedge CLK);
      check("count_three", 32'(COUNT), 32'd3);
`ifdef UART_ECHO_TX_EN
      k = 0;
      while (!TX_SEND && k < LCD_GAP + 60) begin
         @(negedge CLK);
         k++;
      end
      check("tx_send_before_rst", 32'(TX_SEND), 32'd1);
      @(negedge CLK);
`endif
      RST = 1'b0;
      #1;
      check_reset_state();
      model_reset();
      repeat (5) @(negedge CLK);
      RST = 1'b1;
      wait_drain();

      // 33 characters from column 0: line change before 17th, clear before 33rd
      sent = 0;
      while (sent < 2*LCD_COLS + 1) begin
         for (int i = 0; i < 8 && sent < 2*LCD_COLS + 1; i++) begin
            xfer(8'($urandom), 1'b1);
            sent++;
         end
         wait_drain();
      end

      // random batches with random spacing
      for (int r = 0; r < 5; r++) begin
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            xfer(8'($urandom), 1'b1);
            repeat ($urandom_range(0, 5)) @(negedge CLK);
         end
         wait_drain();
      end

      check("lcd_queue_empty", 32'(exp_lcd.size()), 32'd0);
`ifdef UART_ECHO_TX_EN
      check("tx_idle_end", 32'(TX_SEND), 32'd0);
`else
      check("tx_send_never", 32'(tx_seen), 32'd0);
      check("tx_data_zero", 32'(TX_DATA), 32'd0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #3000000;
      $display("FAIL watchdog: got time limit, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
